// File: rtl/gpio_bank_ctrl_if.sv
// Avalon-MM slave bus bundle for gpio_bank_ctrl: 3-bit address, 32-bit data, active-low write strobe.
interface gpio_bank_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/gpio_bank_ctrl.sv
// Parametrised Avalon-MM GPIO bank: per-bit direction, input synchroniser, edge capture with W1C and level irq.
// Optional per-bit debounce filter is built only when GPIO_DEBOUNCE_EN is defined.
module gpio_bank_ctrl #(
    parameter int unsigned       WIDTH           = 8,
    parameter int unsigned       SYNC_STAGES     = 2,
    parameter logic [WIDTH-1:0]  RESET_OUT       = {WIDTH{1'b0}},
    parameter int unsigned       DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    gpio_bank_ctrl_if.slave      bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic [WIDTH-1:0]     out_port,
    output logic [WIDTH-1:0]     oe,
    output logic                 irq
);

    if ((WIDTH < 1) || (WIDTH > 32)) begin : g_bad_width
        $error("gpio_bank_ctrl: WIDTH out of range");
    end
    if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_sync
        $error("gpio_bank_ctrl: SYNC_STAGES out of range");
    end
    if ((DEBOUNCE_CYCLES < 1) || (DEBOUNCE_CYCLES > 65535)) begin : g_bad_db
        $error("gpio_bank_ctrl: DEBOUNCE_CYCLES out of range");
    end

    logic [WIDTH-1:0]                   r_data_out;
    logic [WIDTH-1:0]                   r_dir;
    logic [WIDTH-1:0]                   r_mask;
    logic [WIDTH-1:0]                   r_capture;
    logic [WIDTH-1:0]                   r_rise_en;
    logic [WIDTH-1:0]                   r_fall_en;
    logic [WIDTH-1:0]                   r_prev;
    logic [SYNC_STAGES-1:0][WIDTH-1:0]  r_sync;
    logic [31:0]                        r_readdata;

    logic                               w_wr;
    logic [WIDTH-1:0]                   w_wd;
    logic [WIDTH-1:0]                   w_sync_in;
    logic [WIDTH-1:0]                   w_filt;
    logic [WIDTH-1:0]                   w_edge;
    logic [WIDTH-1:0]                   w_clr;
    logic [31:0]                        w_rd_mux;

    assign w_wr      = bus.chipselect & ~bus.write_n;
    assign w_wd      = bus.writedata[WIDTH-1:0];
    assign w_sync_in = r_sync[SYNC_STAGES-1];

    // Input synchroniser chain: stage 0 samples the asynchronous pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= {(SYNC_STAGES*WIDTH){1'b0}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0][15:0] r_db_cnt;
    logic [WIDTH-1:0]       r_filt;

    // Debounce: a bit must disagree with the filtered value for DEBOUNCE_CYCLES clocks to propagate.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_db_cnt <= {(WIDTH*16){1'b0}};
            r_filt   <= {WIDTH{1'b0}};
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (w_sync_in[i] != r_filt[i]) begin
                    if (r_db_cnt[i] == DB_LAST) begin
                        r_filt[i]   <= w_sync_in[i];
                        r_db_cnt[i] <= 16'd0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 16'd1;
                    end
                end else begin
                    r_db_cnt[i] <= 16'd0;
                end
            end
        end
    end

    assign w_filt = r_filt;
`else
    assign w_filt = w_sync_in;
`endif

    assign w_edge = (w_filt & ~r_prev & r_rise_en) | (~w_filt & r_prev & r_fall_en);

    // W1C clear mask, only live on a CAPTURE write.
    always_comb begin
        w_clr = {WIDTH{1'b0}};
        if (w_wr && (bus.address == 3'd3)) begin
            w_clr = w_wd;
        end else begin
            w_clr = {WIDTH{1'b0}};
        end
    end

    // Edge history and capture; a new edge wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev    <= {WIDTH{1'b0}};
            r_capture <= {WIDTH{1'b0}};
        end else begin
            r_prev    <= w_filt;
            r_capture <= (r_capture & ~w_clr) | w_edge;
        end
    end

    // Control register writes; reset takes priority over any bus write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out <= RESET_OUT;
            r_dir      <= {WIDTH{1'b0}};
            r_mask     <= {WIDTH{1'b0}};
            r_rise_en  <= {WIDTH{1'b0}};
            r_fall_en  <= {WIDTH{1'b0}};
        end else if (w_wr) begin
            case (bus.address)
                3'd0:    r_data_out <= w_wd;
                3'd1:    r_dir      <= w_wd;
                3'd2:    r_mask     <= w_wd;
                3'd4:    r_data_out <= r_data_out | w_wd;
                3'd5:    r_data_out <= r_data_out & ~w_wd;
                3'd6:    r_rise_en  <= w_wd;
                3'd7:    r_fall_en  <= w_wd;
                default: r_data_out <= r_data_out;
            endcase
        end
    end

    // Read mux, zero-extended above WIDTH; OUTSET/OUTCLR read as zero.
    always_comb begin
        w_rd_mux = 32'd0;
        case (bus.address)
            3'd0:    w_rd_mux[WIDTH-1:0] = (r_dir & r_data_out) | (~r_dir & w_filt);
            3'd1:    w_rd_mux[WIDTH-1:0] = r_dir;
            3'd2:    w_rd_mux[WIDTH-1:0] = r_mask;
            3'd3:    w_rd_mux[WIDTH-1:0] = r_capture;
            3'd6:    w_rd_mux[WIDTH-1:0] = r_rise_en;
            3'd7:    w_rd_mux[WIDTH-1:0] = r_fall_en;
            default: w_rd_mux = 32'd0;
        endcase
    end

    // Registered read data, updated every clock regardless of chipselect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= 32'd0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign bus.readdata = r_readdata;
    assign out_port     = r_data_out;
    assign oe           = r_dir;
    assign irq          = |(r_capture & r_mask);

endmodule
